// File: rtl/macc_sched_pkg.sv
// Shared definitions for the shared-MACC scheduler: opcodes, fixed datapath widths,
// pipeline payload structs and the accumulate helper used by the write-back stage.
// No logic of its own; imported by macc_rr_arb and macc_sched.
package macc_sched_pkg;

    localparam int ID_W  = 3;              // requester index width (up to 8 requesters)
    localparam int A_FIX = 18;             // multiplier port A width
    localparam int B_FIX = 25;             // multiplier port B width
    localparam int P_W   = A_FIX + B_FIX;  // full product width (43)
    localparam int ACC_W = 48;             // accumulator / result width

    typedef enum logic [1:0] {
        OP_MUL  = 2'd0,
        OP_MAC  = 2'd1,
        OP_CLR  = 2'd2,
        OP_READ = 2'd3
    } op_t;

    // Issue stage payload: operands already zero-extended to the fixed port widths.
    typedef struct packed {
        logic [ID_W-1:0]  id;
        op_t              op;
        logic [A_FIX-1:0] a;
        logic [B_FIX-1:0] b;
    } issue_t;

    // Product stage payload.
    typedef struct packed {
        logic [ID_W-1:0] id;
        op_t             op;
        logic [P_W-1:0]  prod;
    } prod_t;

    // Returns {carry, new_acc}. Carry is only meaningful for MAC; other ops return 0.
    function automatic logic [ACC_W:0] acc_update(input op_t              op,
                                                  input logic [ACC_W-1:0] acc,
                                                  input logic [P_W-1:0]   prod);
        logic [ACC_W:0] sum;
        sum = {1'b0, acc} + {{(ACC_W + 1 - P_W){1'b0}}, prod};
        case (op)
            OP_MUL:  acc_update = {{(ACC_W + 1 - P_W){1'b0}}, prod};
            OP_MAC:  acc_update = sum;
            OP_CLR:  acc_update = '0;
            default: acc_update = {1'b0, acc};
        endcase
    endfunction

endpackage

// File: rtl/macc_rr_arb.sv
// Round-robin arbiter: picks the first valid requester at or after the pointer.
// Latency: combinational grant; pointer moves to winner+1 on the granting edge.
// Backpressure: en=0 suppresses all grants and freezes the pointer.
// Ports: clk/resetn; en (grant enable); req (per-requester valid);
//        gnt (one-hot or zero), gnt_idx (encoded winner), gnt_vld (a grant is issued).
module macc_rr_arb
    import macc_sched_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            en,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [ID_W-1:0] gnt_idx,
    output logic            gnt_vld
);

    logic [ID_W-1:0] ptr;
    int              win;
    int              best_d;
    int              d;

    // Winner is the valid requester with the smallest rotational distance from ptr.
    always_comb begin
        win    = 0;
        best_d = NREQ;
        d      = 0;
        for (int i = 0; i < NREQ; i++) begin
            d = (i - int'(ptr) + NREQ) % NREQ;
            if (req[i] && (d < best_d)) begin
                best_d = d;
                win    = i;
            end
        end
    end

    assign gnt_vld = en && (best_d < NREQ);
    assign gnt_idx = ID_W'(win);
    assign gnt     = gnt_vld ? (NREQ'(1) << win) : '0;

    // A grant is always a transfer (ready is only raised where valid is high).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr <= '0;
        end else if (gnt_vld) begin
            ptr <= ID_W'((win + 1) % NREQ);
        end
    end

endmodule

// File: rtl/macc_sched.sv
// Shared 18x25 MACC scheduler with one private 48-bit accumulator per requester.
// Latency: accept at edge T -> response valid after edge T+3; 1 op/cycle sustained.
// Backpressure: rsp_valid && !rsp_ready freezes every stage and the arbiter; req_ready all 0.
// Ports: req_valid/req_ready/req_op/req_a/req_b per requester (flattened, index 0 at LSBs);
//        rsp_valid/rsp_ready/rsp_id/rsp_data/rsp_ovf single response port; busy = work pending.
module macc_sched
    import macc_sched_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int A_WIDTH   = 18,
    parameter int B_WIDTH   = 25,
    parameter int ACC_WIDTH = 48
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [2*NREQ-1:0]       req_op,
    input  logic [A_WIDTH*NREQ-1:0] req_a,
    input  logic [B_WIDTH*NREQ-1:0] req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [ACC_WIDTH-1:0]    rsp_data,
    output logic                    rsp_ovf,
    output logic                    busy
);

    logic            adv;
    logic [NREQ-1:0] gnt;
    logic [ID_W-1:0] gnt_idx;
    logic            gnt_vld;
    issue_t          sel;

    logic            s0_vld, s1_vld, s2_vld;
    issue_t          s0;
    prod_t           s1, s2;

    logic [ACC_W-1:0] acc [NREQ];
    logic [ACC_W-1:0] acc_rd;
    logic [ACC_W:0]   upd;

    // The whole pipeline moves together; a held response blocks everything behind it.
    assign adv = !(rsp_valid && !rsp_ready);

    // resetn in the enable keeps req_ready low while reset is asserted.
    macc_rr_arb #(.NREQ(NREQ)) u_arb (
        .clk     (clk),
        .resetn  (resetn),
        .en      (adv && resetn),
        .req     (req_valid),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    assign req_ready = gnt;

    // Select the winner's opcode and operands, zero-extending to the multiplier ports.
    always_comb begin
        sel    = '0;
        sel.id = gnt_idx;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel.op = op_t'(req_op[2*i +: 2]);
                sel.a  = A_FIX'(req_a[A_WIDTH*i +: A_WIDTH]);
                sel.b  = B_FIX'(req_b[B_WIDTH*i +: B_WIDTH]);
            end
        end
    end

    // S0 issue, S1 product, S2 operand hold for the accumulate.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s0_vld <= 1'b0;
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
            s0     <= '0;
            s1     <= '0;
            s2     <= '0;
        end else if (adv) begin
            s0_vld <= gnt_vld;
            if (gnt_vld) begin
                s0 <= sel;
            end
            s1_vld  <= s0_vld;
            s1.id   <= s0.id;
            s1.op   <= s0.op;
            s1.prod <= P_W'(s0.a) * P_W'(s0.b);
            s2_vld  <= s1_vld;
            s2      <= s1;
        end
    end

    // Accumulator read and write both happen at S2, so same-id back-to-back ops
    // always see the previous op's result without forwarding.
    always_comb begin
        acc_rd = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (s2.id == ID_W'(i)) begin
                acc_rd = acc[i];
            end
        end
    end

    assign upd = acc_update(s2.op, acc_rd, s2.prod);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_ovf   <= 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                acc[i] <= '0;
            end
        end else if (adv) begin
            rsp_valid <= s2_vld;
            if (s2_vld) begin
                rsp_id   <= s2.id;
                rsp_data <= upd[ACC_W-1:0];
                rsp_ovf  <= upd[ACC_W];
                for (int i = 0; i < NREQ; i++) begin
                    if (s2.id == ID_W'(i)) begin
                        acc[i] <= upd[ACC_W-1:0];
                    end
                end
            end
        end
    end

    assign busy = s0_vld || s1_vld || s2_vld || rsp_valid;

endmodule

// File: tb/tb_macc_sched.sv
module tb_macc_sched;

    localparam int NREQ = 4;
    localparam int AW   = 18;
    localparam int BW   = 25;

    logic                 clk = 1'b0;
    logic                 resetn;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [2*NREQ-1:0]    req_op;
    logic [AW*NREQ-1:0]   req_a;
    logic [BW*NREQ-1:0]   req_b;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [2:0]           rsp_id;
    logic [47:0]          rsp_data;
    logic                 rsp_ovf;
    logic                 busy;

    macc_sched #(.NREQ(NREQ), .A_WIDTH(AW), .B_WIDTH(BW), .ACC_WIDTH(48)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_ovf   (rsp_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: per-id accumulators, RR pointer, and a queue of expected
    // responses stamped with the advancing-edge count at which each must appear.
    typedef struct {
        int          id;
        logic [47:0] data;
        logic        ovf;
        longint      due;
    } exp_t;

    logic [47:0] m_acc [NREQ];
    int          m_ptr;
    longint      adv_cnt;
    exp_t        q[$];
    int          last_w;
    int          cyc_n = 0;

    int          got_id[$];
    logic [47:0] got_data[$];
    logic        got_ovf[$];
    int          got_cyc[$];
    int          acc_log[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < NREQ; i++) m_acc[i] = '0;
        m_ptr   = 0;
        adv_cnt = 0;
    endtask

    task automatic clear_logs();
        got_id.delete();
        got_data.delete();
        got_ovf.delete();
        got_cyc.delete();
        acc_log.delete();
    endtask

    task automatic set_req(input int i, input logic v, input logic [1:0] o,
                           input logic [AW-1:0] a, input logic [BW-1:0] b);
        req_valid[i]       = v;
        req_op[2*i +: 2]   = o;
        req_a[AW*i +: AW]  = a;
        req_b[BW*i +: BW]  = b;
    endtask

    // One clock: sample at negedge, check against the model, advance the model,
    // return at posedge+1 so the caller can drive the next inputs.
    task automatic cyc();
        logic            exp_vld;
        logic            stall;
        logic [NREQ-1:0] exp_rdy;
        int              w;
        int              c;
        logic [AW-1:0]   ma;
        logic [BW-1:0]   mb;
        logic [1:0]      mo;
        logic [63:0]     p;
        logic [63:0]     s;
        exp_t            e;
        @(negedge clk);
        cyc_n++;
        exp_vld = (q.size() != 0) && (q[0].due == adv_cnt);
        chk("rsp_valid", rsp_valid, exp_vld);
        if (exp_vld) begin
            chk("rsp_id", rsp_id, q[0].id);
            chk("rsp_data", rsp_data, q[0].data);
            chk("rsp_ovf", rsp_ovf, q[0].ovf);
            if (rsp_ready) begin
                got_id.push_back(int'(rsp_id));
                got_data.push_back(rsp_data);
                got_ovf.push_back(rsp_ovf);
                got_cyc.push_back(cyc_n);
                void'(q.pop_front());
            end
        end
        stall = exp_vld && !rsp_ready;
        w = -1;
        if (!stall) begin
            for (int k = 0; k < NREQ; k++) begin
                c = (m_ptr + k) % NREQ;
                if (w < 0 && req_valid[c]) w = c;
            end
        end
        exp_rdy = '0;
        if (w >= 0) exp_rdy[w] = 1'b1;
        chk("req_ready", req_ready, exp_rdy);
        if (w >= 0) begin
            ma = req_a[AW*w +: AW];
            mb = req_b[BW*w +: BW];
            mo = req_op[2*w +: 2];
            p  = 64'(ma) * 64'(mb);
            e.id  = w;
            e.due = adv_cnt + 4;
            e.ovf = 1'b0;
            case (mo)
                2'd0: m_acc[w] = p[47:0];
                2'd1: begin
                    s = 64'(m_acc[w]) + p;
                    m_acc[w] = s[47:0];
                    e.ovf = s[48];
                end
                2'd2: m_acc[w] = '0;
                default: ;
            endcase
            e.data = m_acc[w];
            q.push_back(e);
            acc_log.push_back(w);
            m_ptr = (w + 1) % NREQ;
        end
        last_w = w;
        if (!stall) adv_cnt++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [63:0] pmax;
        logic [63:0] wexp;
        logic [47:0] held_data;
        logic [2:0]  held_id;
        logic        ok;
        int          novf;

        resetn    = 1'b0;
        rsp_ready = 1'b1;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        model_reset();

        // Reset state, with requests pending to show ready is held low.
        req_valid = '1;
        repeat (2) @(negedge clk);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_id", rsp_id, 3'd0);
        chk("rst_rsp_data", rsp_data, 48'd0);
        chk("rst_rsp_ovf", rsp_ovf, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_req_ready", req_ready, 4'b0000);
        req_valid = '0;
        @(posedge clk);
        #1;
        resetn = 1'b1;

        // Single MUL, exact 3-cycle latency.
        clear_logs();
        set_req(0, 1'b1, 2'd0, 18'd1000, 25'd3000);
        cyc();
        chk("t1_grant", last_w, 0);
        set_req(0, 1'b0, 2'd0, '0, '0);
        chk("t1_busy", busy, 1'b1);
        cyc();
        cyc();
        cyc();
        chk("t1_rsp_valid", rsp_valid, 1'b1);
        chk("t1_rsp_id", rsp_id, 3'd0);
        chk("t1_rsp_data", rsp_data, 48'd3000000);
        chk("t1_rsp_ovf", rsp_ovf, 1'b0);
        cyc();
        chk("t1_idle", busy, 1'b0);

        // CLR then three back-to-back MACs on requester 1.
        clear_logs();
        for (int k = 0; k < 4; k++) begin
            set_req(1, 1'b1, (k == 0) ? 2'd2 : 2'd1, 18'd2, 25'd5);
            cyc();
            chk("t2_grant", last_w, 1);
        end
        set_req(1, 1'b0, 2'd0, '0, '0);
        repeat (5) cyc();
        chk("t2_count", got_data.size(), 4);
        if (got_data.size() == 4) begin
            for (int k = 1; k < 4; k++) begin
                chk("t2_mac_data", got_data[k], 64'(10 * k));
                chk("t2_consecutive", got_cyc[k], got_cyc[k-1] + 1);
            end
        end

        // All four requesters READ continuously; pointer sits at 2 after the above.
        clear_logs();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 2'd3, '0, '0);
        repeat (12) cyc();
        req_valid = '0;
        repeat (5) cyc();
        chk("t4_accepts", acc_log.size(), 12);
        chk("t4_rsps", got_id.size(), 12);
        for (int k = 0; k < 12 && k < acc_log.size() && k < got_id.size(); k++) begin
            chk("t4_grant_order", acc_log[k], (2 + k) % NREQ);
            chk("t4_rsp_order", got_id[k], (2 + k) % NREQ);
        end

        // Max-operand MUL then 33 MACs: wrap happens once, on the 32nd MAC.
        clear_logs();
        for (int k = 0; k < 34; k++) begin
            set_req(2, 1'b1, (k == 0) ? 2'd0 : 2'd1, 18'h3FFFF, 25'h1FFFFFF);
            cyc();
        end
        set_req(2, 1'b0, 2'd0, '0, '0);
        repeat (6) cyc();
        chk("t5_count", got_data.size(), 34);
        pmax = 64'((2**18) - 1) * 64'((2**25) - 1);
        novf = 0;
        for (int k = 0; k < got_ovf.size(); k++) begin
            if (got_ovf[k]) novf++;
            chk("t5_ovf_pos", got_ovf[k], (k == 32) ? 1'b1 : 1'b0);
        end
        chk("t5_ovf_count", novf, 1);
        wexp = (64'd34 * pmax) & 64'hFFFF_FFFF_FFFF;
        if (got_data.size() == 34) chk("t5_wrapped", got_data[33], wexp);

        // Response stall with three ops in flight.
        clear_logs();
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_req(3, 1'b1, 2'd0, 18'(k + 1), 25'd7);
            cyc();
        end
        set_req(3, 1'b0, 2'd0, '0, '0);
        ok = 1'b0;
        for (int n = 0; n < 8; n++) begin
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
        chk("t6_stall_reached", ok, 1'b1);
        held_data = rsp_data;
        held_id   = rsp_id;
        set_req(0, 1'b1, 2'd3, '0, '0);
        for (int n = 0; n < 5; n++) begin
            cyc();
            chk("t6_hold_valid", rsp_valid, 1'b1);
            chk("t6_hold_data", rsp_data, held_data);
            chk("t6_hold_id", rsp_id, held_id);
            chk("t6_no_ready", req_ready, 4'b0000);
        end
        rsp_ready = 1'b1;
        for (int n = 0; n < 10; n++) begin
            cyc();
            if (last_w == 0) req_valid[0] = 1'b0;
        end
        chk("t6_count", got_id.size(), 4);
        if (got_id.size() == 4) begin
            chk("t6_d0", got_data[0], 48'd7);
            chk("t6_d1", got_data[1], 48'd14);
            chk("t6_d2", got_data[2], 48'd21);
            chk("t6_id3", got_id[3], 0);
            chk("t6_d3", got_data[3], 48'd3000000);
        end

        // Reset with two MACs in flight.
        clear_logs();
        set_req(0, 1'b1, 2'd1, 18'd1, 25'd1);
        set_req(1, 1'b1, 2'd1, 18'd1, 25'd1);
        cyc();
        if (last_w >= 0) req_valid[last_w] = 1'b0;
        cyc();
        if (last_w >= 0) req_valid[last_w] = 1'b0;
        chk("t7_inflight", busy, 1'b1);
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 2'd3, '0, '0);
        #3;
        resetn = 1'b0;
        #1;
        chk("t7_rst_valid", rsp_valid, 1'b0);
        chk("t7_rst_busy", busy, 1'b0);
        chk("t7_rst_ready", req_ready, 4'b0000);
        chk("t7_rst_data", rsp_data, 48'd0);
        model_reset();
        @(negedge clk);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        clear_logs();
        repeat (4) cyc();
        req_valid = '0;
        repeat (6) cyc();
        if (acc_log.size() > 0) chk("t7_first_grant", acc_log[0], 0);
        chk("t7_count", got_id.size(), 4);
        for (int k = 0; k < got_id.size(); k++) begin
            chk("t7_read_zero", got_data[k], 48'd0);
            chk("t7_read_id", got_id[k], k);
        end

        // Randomized traffic with random response backpressure.
        for (int n = 0; n < 600; n++) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            cyc();
            if (last_w >= 0) req_valid[last_w] = 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
                    set_req(i, 1'b1, 2'($urandom_range(0, 3)),
                            ($urandom_range(0, 3) == 0) ? 18'h3FFFF : 18'($urandom),
                            ($urandom_range(0, 3) == 0) ? 25'h1FFFFFF : 25'($urandom));
                end
            end
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (8) cyc();
        chk("rand_drained", q.size(), 0);
        chk("rand_idle", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
